ram_uart_streamer: RTL

RAM_UART_STREAMER -- requirements
Module: ram_uart_streamer

---
 rtl/ram_uart_streamer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ram_uart_streamer.sv
// rtl/ram_uart_streamer.sv - streams a block of RAM words byte-wise to a UART transmitter
// Reads WORDS words from BASE upward and sends each word LSB byte first.

module ram_uart_streamer #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 8,
    parameter int BASE         = 0,
    parameter int WORDS        = 134,
    parameter int PAUSE_CYCLES = 50000000,
    parameter int CONTINUOUS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] q_ram,
    output logic [ADDR_W-1:0] a_ram,
    output logic              clock_ram,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int B_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [B_W-1:0]    LAST_BYTE = B_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = (PAUSE_CYCLES > 1) ? CNT_W'(PAUSE_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_ADDR,
        S_READ,
        S_LATCH,
        S_SEND,
        S_GUARD,
        S_WAIT_TX,
        S_NEXT,
        S_PAUSE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [B_W-1:0]      byte_q, byte_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   a_ram_q, a_ram_d;
    logic                clock_ram_q, clock_ram_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_pend;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        abort_pend = abort_q | abort;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SET_ADDR;
                    idx_d   = '0;
                    byte_d  = '0;
                end
            end
            S_SET_ADDR: state_d = abort_pend ? S_IDLE : S_READ;
            S_READ:     state_d = S_LATCH;
            S_LATCH: begin
                word_d  = q_ram;
                byte_d  = '0;
                state_d = S_SEND;
            end
            S_SEND:     state_d = S_GUARD;
            S_GUARD:    state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                // An abort only takes effect once the byte on the wire has finished.
                if (!tx_busy) begin
                    if (abort_pend) begin
                        state_d = S_IDLE;
                    end else if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        word_d  = word_q >> 8;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SET_ADDR;
                end else begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (CONTINUOUS != 0) ? S_PAUSE : S_IDLE;
                end
            end
            S_PAUSE: begin
                if (abort_pend) begin
                    state_d = S_IDLE;
                end else if ((PAUSE_CYCLES <= 1) || (cnt_q == LAST_CNT)) begin
                    state_d = S_SET_ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet line up with it.
        abort_d     = (state_d == S_IDLE) ? 1'b0 : abort_pend;
        clock_ram_d = (state_d == S_READ);
        tx_start_d  = (state_d == S_SEND);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_NEXT) && (idx_d == LAST_IDX);
        a_ram_d     = (state_d == S_SET_ADDR) ? (BASE_A + ADDR_W'(idx_d)) : a_ram_q;
        tx_data_d   = (state_d == S_SEND) ? word_d[7:0] : tx_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            word_q      <= '0;
            a_ram_q     <= '0;
            clock_ram_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            word_q      <= word_d;
            a_ram_q     <= a_ram_d;
            clock_ram_q <= clock_ram_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_ram     = a_ram_q;
    assign clock_ram = clock_ram_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
